// File: rtl/fp_pending_scoreboard_pkg.sv
// Shared defaults and types for the FP pending-write scoreboard.
package fp_sb_pkg;

    localparam int FP_SB_TOTAL_REGS = 32;
    localparam int FP_SB_CNT_W      = 2;
    localparam int FP_SB_NUM_WB     = 2;

    typedef logic [FP_SB_CNT_W-1:0] fp_sb_cnt_t;

    function automatic int fp_sb_cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/fp_pending_scoreboard_if.sv
// Issue / source-check / write-back / query bundle between ID and the FP scoreboard.
interface fp_pending_scoreboard_if
    import fp_sb_pkg::*;
#(
    parameter int TOTAL_REGS = FP_SB_TOTAL_REGS,
    parameter int NUM_SRC    = 3,
    parameter int NUM_WB     = FP_SB_NUM_WB,
    parameter int NUM_QUERY  = 3
);
    localparam int AW = $clog2(TOTAL_REGS);

    logic                          issue_valid;
    logic [AW-1:0]                 issue_rd;
    logic [NUM_SRC-1:0][AW-1:0]    src_addr;
    logic [NUM_SRC-1:0]            src_used;
    logic [NUM_SRC-1:0]            src_fwd;
    logic [NUM_WB-1:0]             wb_valid;
    logic [NUM_WB-1:0][AW-1:0]     wb_addr;
    logic                          flush;
    logic                          stall;
    logic                          issue_accept;
    logic [NUM_QUERY-1:0][AW-1:0]  query_addr;
    logic [NUM_QUERY-1:0]          query_busy;
    logic [TOTAL_REGS-1:0]         busy_vec;
    logic                          underflow_err;
    logic                          no_dependency;

    modport master (
        output issue_valid, issue_rd, src_addr, src_used, src_fwd,
               wb_valid, wb_addr, flush, query_addr,
        input  stall, issue_accept, query_busy, busy_vec,
               underflow_err, no_dependency
    );

    modport slave (
        input  issue_valid, issue_rd, src_addr, src_used, src_fwd,
               wb_valid, wb_addr, flush, query_addr,
        output stall, issue_accept, query_busy, busy_vec,
               underflow_err, no_dependency
    );

endinterface

// File: rtl/fp_pending_scoreboard_counter.sv
// Per-register pending-write counter: +inc, -dec in one step, clamp at zero on underflow.
module fp_sb_counter #(
    parameter int CNT_W = 2,
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);
    localparam int SW = (CNT_W + 1 > DEC_W) ? CNT_W + 1 : DEC_W;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    sum;

    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        sum       = SW'(cnt_q) + SW'(inc);
        if (flush) begin
            cnt_d = '0;
        end else if (SW'(dec) > sum) begin
            cnt_d     = '0;
            underflow = 1'b1;
        end else begin
            // Upper bound is held by the issue stall, so truncation never drops a set bit.
            cnt_d = CNT_W'(sum - SW'(dec));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fp_pending_scoreboard.sv
// FP register pending-write scoreboard: RAW stall, write-port saturation stall, busy queries.
module fp_pending_scoreboard
    import fp_sb_pkg::*;
#(
    parameter int TOTAL_REGS = FP_SB_TOTAL_REGS,
    parameter int NUM_SRC    = 3,
    parameter int NUM_WB     = FP_SB_NUM_WB,
    parameter int NUM_QUERY  = 3,
    parameter int CNT_W      = FP_SB_CNT_W
) (
    input  logic clk,
    input  logic reset,
    fp_pending_scoreboard_if.slave sb
);
    localparam int AW      = $clog2(TOTAL_REGS);
    localparam int DEC_W   = $clog2(NUM_WB + 1);
    localparam int CNT_MAX = fp_sb_cnt_max(CNT_W);

    logic [CNT_W-1:0]      cnt [TOTAL_REGS];
    logic [DEC_W-1:0]      dec [TOTAL_REGS];
    logic [TOTAL_REGS-1:0] busy;
    logic [TOTAL_REGS-1:0] inc;
    logic [TOTAL_REGS-1:0] uf;
    logic                  raw_hazard;
    logic                  rd_full;
    logic                  stall;
    logic                  accept;
    logic                  no_dep;
    logic [NUM_QUERY-1:0]  query_busy;
    logic                  underflow_err_q, underflow_err_d;

    always_comb begin
        for (int unsigned i = 0; i < unsigned'(TOTAL_REGS); i++) begin
            busy[i] = (cnt[i] != '0);
        end
    end

    // Hazards look only at registered counts; a same-cycle write-back does not unblock.
    always_comb begin
        raw_hazard = 1'b0;
        no_dep     = 1'b1;
        for (int unsigned i = 0; i < unsigned'(NUM_SRC); i++) begin
            if (sb.src_used[i] && busy[sb.src_addr[i]]) begin
                no_dep = 1'b0;
                if (!sb.src_fwd[i]) raw_hazard = 1'b1;
            end
        end
        rd_full = (cnt[sb.issue_rd] == CNT_W'(CNT_MAX));
        stall   = sb.issue_valid & (raw_hazard | rd_full);
        accept  = sb.issue_valid & ~stall;
    end

    always_comb begin
        for (int unsigned i = 0; i < unsigned'(TOTAL_REGS); i++) begin
            inc[i] = accept && (sb.issue_rd == AW'(i));
            dec[i] = '0;
            for (int unsigned j = 0; j < unsigned'(NUM_WB); j++) begin
                if (sb.wb_valid[j] && (sb.wb_addr[j] == AW'(i))) begin
                    dec[i] = dec[i] + DEC_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < unsigned'(NUM_QUERY); k++) begin
            query_busy[k] = busy[sb.query_addr[k]];
        end
    end

    genvar g;
    generate
        for (g = 0; g < TOTAL_REGS; g++) begin : g_cnt
            fp_sb_counter #(
                .CNT_W (CNT_W),
                .DEC_W (DEC_W)
            ) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .inc       (inc[g]),
                .dec       (dec[g]),
                .flush     (sb.flush),
                .cnt       (cnt[g]),
                .underflow (uf[g])
            );
        end
    endgenerate

    always_comb begin
        underflow_err_d = underflow_err_q | (|uf);
    end

    always_ff @(posedge clk) begin
        if (reset) underflow_err_q <= 1'b0;
        else       underflow_err_q <= underflow_err_d;
    end

    assign sb.stall         = stall;
    assign sb.issue_accept  = accept;
    assign sb.no_dependency = no_dep;
    assign sb.busy_vec      = busy;
    assign sb.query_busy    = query_busy;
    assign sb.underflow_err = underflow_err_q;

endmodule

// File: tb/tb_fp_pending_scoreboard.sv
// Directed vector table plus hand sequences for reset, f0, underflow stickiness.
module tb_fp_pending_scoreboard;
    import fp_sb_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    fp_pending_scoreboard_if #(
        .TOTAL_REGS (32),
        .NUM_SRC    (3),
        .NUM_WB     (2),
        .NUM_QUERY  (3)
    ) sb_if ();

    fp_pending_scoreboard #(
        .TOTAL_REGS (32),
        .NUM_SRC    (3),
        .NUM_WB     (2),
        .NUM_QUERY  (3),
        .CNT_W      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            iv;
        logic [4:0]      rd;
        logic [2:0][4:0] sa;
        logic [2:0]      su;
        logic [2:0]      sf;
        logic [1:0]      wv;
        logic [1:0][4:0] wa;
        logic            fl;
        logic [2:0][4:0] qa;
        logic            es;
        logic            ea;
        logic            en;
        logic [31:0]     eb;
        logic [2:0]      eq;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic idle_inputs();
        sb_if.issue_valid = 1'b0;
        sb_if.issue_rd    = '0;
        sb_if.src_addr    = '0;
        sb_if.src_used    = '0;
        sb_if.src_fwd     = '0;
        sb_if.wb_valid    = '0;
        sb_if.wb_addr     = '0;
        sb_if.flush       = 1'b0;
    endtask

    initial begin
        logic [2:0][4:0] q, q2, q3, z;
        fp_sb_cnt_t      unused_cnt;
        total  = 0;
        passed = 0;
        unused_cnt = '0;
        q  = {5'd3, 5'd7, 5'd5};
        q2 = {5'd31, 5'd2, 5'd1};
        q3 = {5'd31, 5'd4, 5'd1};
        z  = '0;

        //        iv    rd     sa                      su      sf      wv     wa               fl    qa  es    ea    en    eb             eq
        vt[0]  = '{1'b0, 5'd0,  z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b0, 1'b1, 32'h0,         3'b000};
        vt[1]  = '{1'b1, 5'd5,  z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b1, 1'b1, 32'h0,         3'b000};
        vt[2]  = '{1'b1, 5'd10, {5'd0, 5'd0, 5'd5},     3'b001, 3'b000, 2'b01, {5'd0, 5'd5},    1'b0, q,  1'b1, 1'b0, 1'b0, 32'h20,        3'b001};
        vt[3]  = '{1'b1, 5'd10, {5'd0, 5'd0, 5'd5},     3'b001, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b1, 1'b1, 32'h0,         3'b000};
        vt[4]  = '{1'b1, 5'd7,  z,                      3'b000, 3'b000, 2'b01, {5'd0, 5'd10},   1'b0, q,  1'b0, 1'b1, 1'b1, 32'h400,       3'b000};
        vt[5]  = '{1'b1, 5'd7,  z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b1, 1'b1, 32'h80,        3'b010};
        vt[6]  = '{1'b1, 5'd7,  z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b1, 1'b1, 32'h80,        3'b010};
        vt[7]  = '{1'b1, 5'd7,  z,                      3'b000, 3'b000, 2'b01, {5'd0, 5'd7},    1'b0, q,  1'b1, 1'b0, 1'b1, 32'h80,        3'b010};
        vt[8]  = '{1'b1, 5'd7,  z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b1, 1'b1, 32'h80,        3'b010};
        vt[9]  = '{1'b0, 5'd0,  z,                      3'b000, 3'b000, 2'b11, {5'd7, 5'd7},    1'b0, q,  1'b0, 1'b0, 1'b1, 32'h80,        3'b010};
        vt[10] = '{1'b0, 5'd0,  z,                      3'b000, 3'b000, 2'b01, {5'd0, 5'd7},    1'b0, q,  1'b0, 1'b0, 1'b1, 32'h80,        3'b010};
        vt[11] = '{1'b1, 5'd3,  z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b1, 1'b1, 32'h0,         3'b000};
        vt[12] = '{1'b1, 5'd3,  z,                      3'b000, 3'b000, 2'b01, {5'd0, 5'd3},    1'b0, q,  1'b0, 1'b1, 1'b1, 32'h8,         3'b100};
        vt[13] = '{1'b1, 5'd3,  z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b1, 1'b1, 32'h8,         3'b100};
        vt[14] = '{1'b0, 5'd0,  z,                      3'b000, 3'b000, 2'b11, {5'd3, 5'd3},    1'b0, q,  1'b0, 1'b0, 1'b1, 32'h8,         3'b100};
        vt[15] = '{1'b0, 5'd0,  z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b0, 1'b1, 32'h0,         3'b000};
        vt[16] = '{1'b1, 5'd1,  z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b1, 1'b1, 32'h0,         3'b000};
        vt[17] = '{1'b1, 5'd2,  z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b1, 1'b1, 32'h2,         3'b000};
        vt[18] = '{1'b1, 5'd20, {5'd2, 5'd1, 5'd0},     3'b011, 3'b010, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b1, 1'b0, 32'h6,         3'b000};
        vt[19] = '{1'b1, 5'd21, {5'd2, 5'd1, 5'd0},     3'b100, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b1, 1'b0, 1'b0, 32'h100006,    3'b000};
        vt[20] = '{1'b1, 5'd31, z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q,  1'b0, 1'b1, 1'b1, 32'h100006,    3'b000};
        vt[21] = '{1'b1, 5'd4,  z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b1, q2, 1'b0, 1'b1, 1'b1, 32'h80100006,  3'b111};
        vt[22] = '{1'b0, 5'd0,  z,                      3'b000, 3'b000, 2'b00, {5'd0, 5'd0},    1'b0, q3, 1'b0, 1'b0, 1'b1, 32'h0,         3'b000};

        // Reset cycle carries an issue and a write-back; both must be discarded.
        idle_inputs();
        sb_if.query_addr  = q;
        reset             = 1'b1;
        sb_if.issue_valid = 1'b1;
        sb_if.issue_rd    = 5'd6;
        sb_if.wb_valid    = 2'b01;
        sb_if.wb_addr     = {5'd0, 5'd9};
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset          = 1'b0;
        sb_if.wb_valid = '0;
        #1;
        check("rst_busy",    0, 32'(sb_if.busy_vec),      32'h0);
        check("rst_qbusy",   0, 32'(sb_if.query_busy),    32'h0);
        check("rst_nodep",   0, 32'(sb_if.no_dependency), 32'h1);
        check("rst_stall",   0, 32'(sb_if.stall),         32'h0);
        check("rst_accept",  0, 32'(sb_if.issue_accept),  32'h1);
        check("rst_uferr",   0, 32'(sb_if.underflow_err), 32'h0);
        sb_if.issue_valid = 1'b0;
        #1;
        check("rst_accept0", 0, 32'(sb_if.issue_accept),  32'h0);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            sb_if.issue_valid = vt[i].iv;
            sb_if.issue_rd    = vt[i].rd;
            sb_if.src_addr    = vt[i].sa;
            sb_if.src_used    = vt[i].su;
            sb_if.src_fwd     = vt[i].sf;
            sb_if.wb_valid    = vt[i].wv;
            sb_if.wb_addr     = vt[i].wa;
            sb_if.flush       = vt[i].fl;
            sb_if.query_addr  = vt[i].qa;
            #1;
            check("stall",  i, 32'(sb_if.stall),         32'(vt[i].es));
            check("accept", i, 32'(sb_if.issue_accept),  32'(vt[i].ea));
            check("nodep",  i, 32'(sb_if.no_dependency), 32'(vt[i].en));
            check("busy",   i, sb_if.busy_vec,           vt[i].eb);
            check("qbusy",  i, 32'(sb_if.query_busy),    32'(vt[i].eq));
            check("uferr",  i, 32'(sb_if.underflow_err), 32'h0);
            @(negedge clk);
        end

        // f0 is an ordinary tracked register.
        idle_inputs();
        sb_if.query_addr  = '0;
        sb_if.issue_valid = 1'b1;
        sb_if.issue_rd    = 5'd0;
        #1;
        check("f0_accept", 0, 32'(sb_if.issue_accept), 32'h1);
        @(negedge clk);
        sb_if.issue_valid = 1'b0;
        #1;
        check("f0_busy",  0, sb_if.busy_vec,         32'h1);
        check("f0_qbusy", 0, 32'(sb_if.query_busy),  32'h7);
        sb_if.wb_valid = 2'b10;
        sb_if.wb_addr  = {5'd0, 5'd0};
        @(negedge clk);
        sb_if.wb_valid = '0;
        #1;
        check("f0_clear", 0, sb_if.busy_vec,        32'h0);
        check("f0_uferr", 0, 32'(sb_if.underflow_err), 32'h0);

        // Underflow on an idle register: clamps, sets sticky error.
        sb_if.wb_valid = 2'b01;
        sb_if.wb_addr  = {5'd0, 5'd9};
        @(negedge clk);
        sb_if.wb_valid = '0;
        #1;
        check("uf_busy", 0, sb_if.busy_vec,            32'h0);
        check("uf_set",  0, 32'(sb_if.underflow_err), 32'h1);
        repeat (10) @(negedge clk);
        #1;
        check("uf_hold", 0, 32'(sb_if.underflow_err), 32'h1);
        sb_if.flush = 1'b1;
        @(negedge clk);
        sb_if.flush = 1'b0;
        #1;
        check("uf_flush", 0, 32'(sb_if.underflow_err), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("uf_reset", 0, 32'(sb_if.underflow_err), 32'h0);
        check("uf_rbusy", 0, sb_if.busy_vec,           32'h0);

        if (unused_cnt != '0) $display("FAIL cnt_type: got %0h expected 0", unused_cnt);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fp_pending_scoreboard.md
FP_PENDING_SCOREBOARD -- requirements
Module: fp_pending_scoreboard

Interface
REQ-001 SHALL have parameter TOTAL_REGS, 32, number of FP architectural registers.
REQ-002 SHALL have parameter NUM_SRC, 3, number of source-operand check ports (rs1/rs2/rs3).
REQ-003 SHALL have parameter NUM_WB, 2, number of write-back clear ports.
REQ-004 SHALL have parameter NUM_QUERY, 3, number of unit-busy query ports.
REQ-005 SHALL have parameter CNT_W, 2, pending-write counter width; max outstanding writes per register = 2^CNT_W-1.
REQ-006 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-high reset, one clock (clk).
REQ-007 SHALL have ports: issue_valid  in  1  ID instruction will write FP reg file; issue_rd  in  $clog2(TOTAL_REGS)  its destination.
REQ-008 SHALL have ports: src_addr  in  [NUM_SRC] x $clog2(TOTAL_REGS)  sources; src_used  in  NUM_SRC  source is read (rs3 only for R4); src_fwd  in  NUM_SRC  forwarding covers that source.
REQ-009 SHALL have ports: wb_valid  in  NUM_WB  FP write-back this cycle; wb_addr  in  [NUM_WB] x $clog2(TOTAL_REGS)  written register.
REQ-010 SHALL have ports: flush  in  1  pipeline flush, drop all pending writes.
REQ-011 SHALL have ports: stall  out  1  ID must hold; issue_accept  out  1  issue registered this cycle.
REQ-012 SHALL have ports: query_addr  in  [NUM_QUERY] x $clog2(TOTAL_REGS); query_busy  out  NUM_QUERY  register has pending writes.
REQ-013 SHALL have ports: busy_vec  out  TOTAL_REGS  per-register (count != 0); underflow_err  out  1  sticky; no_dependency  out  1.

Function
REQ-014 SHALL keep one CNT_W-bit pending counter per register; f0 tracked like any other register.
REQ-015 SHALL compute all hazard outputs combinationally from registered counters only; no same-cycle write-back bypass.
REQ-016 SHALL assert no_dependency when every used source has count 0.
REQ-017 SHALL assert stall = issue_valid & (any i: src_used[i] & busy[src_addr[i]] & ~src_fwd[i]  OR  count[issue_rd] == 2^CNT_W-1).
REQ-018 SHALL assert issue_accept = issue_valid & ~stall; only an accepted issue increments count[issue_rd].
REQ-019 SHALL decrement each register by the number of wb ports matching it that cycle (duplicate addresses across ports each count).
REQ-020 SHALL apply net update next = count + inc - dec for simultaneous issue and write-back to one register, result in one cycle.
REQ-021 SHALL clamp at 0 when decrements exceed count+inc and set underflow_err (sticky until reset).
REQ-022 SHALL never exceed 2^CNT_W-1; saturation is prevented by REQ-017, not by wrap.
REQ-023 SHALL on flush clear all counters at the next edge, overriding issue and write-back that cycle; underflow_err unaffected.
REQ-024 SHALL drive query_busy[k] = busy[query_addr[k]] with zero latency.

Reset
REQ-025 SHALL on reset=1 at a clk edge set all counters 0 and underflow_err 0; reset dominates flush, issue, write-back.
REQ-026 SHALL produce, after reset: busy_vec=0, query_busy=0, no_dependency=1, stall=0, issue_accept=issue_valid.
REQ-027 SHALL discard any issue/write-back presented in a reset cycle.

Structure
REQ-028 SHALL take defaults and typedef fp_sb_cnt_t from shared package fp_sb_pkg (FP_SB_TOTAL_REGS, FP_SB_CNT_W, FP_SB_NUM_WB).
REQ-029 SHALL instantiate sub-module fp_sb_counter (per-register saturating up/down counter with inc, dec-count, flush, underflow flag) via generate, TOTAL_REGS copies.
REQ-030 SHALL fit 120-400 lines RTL; no latches; single always_ff domain on clk.

Verification
REQ-031 Issue rd=5 accepted; next cycle src_addr[0]=5 used, src_fwd=0 -> stall=1, busy_vec[5]=1; wb port0 addr5 -> following cycle stall=0.
REQ-032 CNT_W=2: three accepted issues to rd=7 -> count 3; fourth issue_valid rd=7 -> stall=1, issue_accept=0; one wb to 7 -> fourth accepted next cycle.
REQ-033 Same cycle: issue rd=3 (count 1) and wb0 addr3 -> count stays 1; wb0 and wb1 both addr3 with count 2 -> count 0.
REQ-034 wb addr 9 with count 0 -> count 0, underflow_err=1, stays 1 after 10 idle cycles, cleared only by reset.
REQ-035 Counts nonzero on regs 1,2,31, flush=1 with issue rd=4 same cycle -> next cycle busy_vec=0, reg 4 not busy.
REQ-036 src_used[2]=0 with src_addr[2] busy -> stall=0; src_fwd[1]=1 with src 1 busy -> stall=0, no_dependency=0.
